led_pwm_driver: RTL
===================

// Module: led_pwm_driver
// PURPOSE
//  Downstream stage of the LED register peripheral: consumes its 4-bit LED
//  value and drives the board LED pins with per-LED PWM brightness.
//  Own memory-mapped config port on the same simple sel/we/ready bus as the
//  other peripherals. Outputs go straight to pads (Tang Nano 9K LEDs are active-low).
// PARAMETERS
//  NUM_LEDS   4          LEDs driven; legal 1..4 (one 8-bit duty byte per LED in BRIGHT)
//  BLINK_DIV  13500000   clk cycles per blink half-period (used only with LED_BLINK_EN)
// PORTS
//  clk         in   1         clock
//  reset_n     in   1         asynchronous, active-low reset
//  leds_i      in   NUM_LEDS  LED on/off value from LED register peripheral
//  drv_sel     in   1         bus select for this block
//  drv_we      in   1         1 = write, 0 = read
//  drv_addr    in   2         word address: 0 CTRL, 1 BRIGHT, 2 PRESCALE, 3 STATUS
//  drv_data_i  in   32        write data
//  drv_ready   out  1         single-cycle access acknowledge
//  drv_data_o  out  32        read data, valid while drv_ready=1
//  led_o       out  NUM_LEDS  registered pad outputs
// BEHAVIOUR
//  Reset (async): all state cleared at once; led_o = all 1s (LEDs dark),
//   drv_ready=0, drv_data_o=0, CTRL=0x2, BRIGHT=0xFFFFFFFF, shadow duty=0xFF,
//   PRESCALE=0, prescale cnt=0, pwm_cnt=0. Reset mid-access aborts it, no write.
//  Bus FSM: IDLE, ACK.
//   IDLE: drv_sel=1 -> ACK; addr/we/data captured at that edge.
//   ACK: drv_ready=1 for exactly 1 cycle; write performed at end of ACK;
//    drv_data_o = register value at capture; unconditional -> IDLE.
//   drv_data_o=0 whenever drv_ready=0. drv_sel held high -> one access / 2 cycles.
//   STATUS writes ignored. Unimplemented bits read 0.
//  Registers:
//   CTRL     [0] enable, [1] invert (pin = ~on), [11:8] blink mask (macro only)
//   BRIGHT   [8i+7:8i] duty for LED i; bytes >= NUM_LEDS read 0
//   PRESCALE [15:0] tick divider
//   STATUS   [7:0] pwm_cnt, [8] blink phase (macro only)
//  PWM timing:
//   Prescale cnt runs 0..PRESCALE, then wraps to 0 with tick=1 (PRESCALE=0 -> tick every cycle).
//   pwm_cnt (8b) +1 per tick, 255 -> 0 wrap.
//   Writing PRESCALE clears prescale cnt in the same edge; pwm_cnt is untouched.
//   Shadow duty loads from BRIGHT on the tick where pwm_cnt wraps 255 -> 0
//    (glitch-free). BRIGHT reads return the written value, not the shadow.
//   on[i] = enable & leds_i[i] & (duty[i]==0xFF | pwm_cnt < duty[i]).
//    duty 0x00 = always off; 0xFF = always on.
//   led_o[i] = on[i] ^ invert, registered: 1 cycle from leds_i / pwm_cnt change to pin.
//   enable=0: on=0 but counters keep running.
// CONFIGURATION
//  LED_BLINK_EN defined:
//   blink counter counts 0..BLINK_DIV-1, toggles phase on wrap; phase resets to 1;
//   counter free-runs from reset.
//   on[i] additionally ANDed with (~CTRL[8+i] | phase). CTRL[11:8] R/W; STATUS[8] = phase.
//  LED_BLINK_EN undefined: no blink logic; CTRL[11:8] and STATUS[8] read 0, writes ignored.
// TESTING
//  1 Reset: release reset_n -> led_o=4'hF, CTRL reads 0x2, BRIGHT reads 0xFFFFFFFF, drv_ready=0.
//  2 Handshake: write CTRL=0x3 with sel high 1 cycle -> drv_ready high exactly cycle 2, then low;
//     read-back = 0x3; sel held 6 cycles -> 3 ready pulses.
//  3 Duty: PRESCALE=0, BRIGHT=0x00_FF_40_00, leds_i=4'hF, CTRL=0x1 ->
//     over 256 cycles after next wrap: LED0 high 0, LED1 high 64, LED2 high 256, LED3 high 0.
//  4 Shadow: change BRIGHT byte0 0x40 -> 0x80 at pwm_cnt=100 -> old duty until wrap,
//     then 128-cycle high time; BRIGHT reads 0x80 immediately.
//  5 Prescale: PRESCALE=3 -> STATUS[7:0] increments every 4 cycles;
//     rewrite PRESCALE mid-count -> next tick 4 cycles after the write.
//  6 Blink (LED_BLINK_EN, BLINK_DIV=10): CTRL=0x101, duty 0xFF, leds_i[0]=1 ->
//     led_o[0] toggles every 10 cycles; without macro, CTRL reads 0x1.

Source files
------------

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: per-LED PWM brightness stage behind the LED register block.
// Optional blink gating is compiled in with `define LED_BLINK_EN.
module led_pwm_driver #(
    parameter int NUM_LEDS  = 4,
    parameter int BLINK_DIV = 13500000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] leds_i,
    input  logic                drv_sel,
    input  logic                drv_we,
    input  logic [1:0]          drv_addr,
    input  logic [31:0]         drv_data_i,
    output logic                drv_ready,
    output logic [31:0]         drv_data_o,
    output logic [NUM_LEDS-1:0] led_o
);

    localparam int BW = NUM_LEDS * 8;

    if (NUM_LEDS < 1 || NUM_LEDS > 4 || BLINK_DIV < 1) begin : g_bad_param
        $error("led_pwm_driver: illegal NUM_LEDS or BLINK_DIV");
    end

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]          addr_q;
    logic                we_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic [31:0]         rd_val;
    logic                wr_ctrl;
    logic                wr_bright;
    logic                wr_prescale;
    logic                ctrl_en;
    logic                ctrl_inv;
    logic [BW-1:0]       bright_q;
    logic [BW-1:0]       shadow_q;
    logic [15:0]         prescale_q;
    logic [15:0]         pre_cnt;
    logic [7:0]          pwm_cnt;
    logic                tick;
    logic [NUM_LEDS-1:0] on;
    logic [NUM_LEDS-1:0] blink_gate;

`ifdef LED_BLINK_EN
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0]       blink_cnt;
    logic [NUM_LEDS-1:0] blink_mask;
    logic                phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt  <= '0;
            phase      <= 1'b1;
            blink_mask <= '0;
        end else begin
            if (blink_cnt == CW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + CW'(1);
            end
            if (wr_ctrl)
                blink_mask <= wdata_q[8 +: NUM_LEDS];
        end
    end

    assign blink_gate = ~blink_mask | {NUM_LEDS{phase}};
`else
    assign blink_gate = '1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (drv_sel) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        drv_ready  = (state == ACK);
        drv_data_o = drv_ready ? rdata_q : 32'd0;
    end

    // Read value is frozen at capture so ACK returns pre-access state.
    always_comb begin
        rd_val = '0;
        unique case (drv_addr)
            2'd0: begin
                rd_val[1:0] = {ctrl_inv, ctrl_en};
`ifdef LED_BLINK_EN
                rd_val[8 +: NUM_LEDS] = blink_mask;
`endif
            end
            2'd1: rd_val[BW-1:0] = bright_q;
            2'd2: rd_val[15:0]   = prescale_q;
            2'd3: begin
                rd_val[7:0] = pwm_cnt;
`ifdef LED_BLINK_EN
                rd_val[8] = phase;
`endif
            end
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (state == IDLE && drv_sel) begin
            addr_q  <= drv_addr;
            we_q    <= drv_we;
            wdata_q <= drv_data_i;
            rdata_q <= rd_val;
        end
    end

    assign wr_ctrl     = (state == ACK) && we_q && (addr_q == 2'd0);
    assign wr_bright   = (state == ACK) && we_q && (addr_q == 2'd1);
    assign wr_prescale = (state == ACK) && we_q && (addr_q == 2'd2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en    <= 1'b0;
            ctrl_inv   <= 1'b1;
            bright_q   <= '1;
            prescale_q <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en  <= wdata_q[0];
                ctrl_inv <= wdata_q[1];
            end
            if (wr_bright)
                bright_q <= wdata_q[BW-1:0];
            if (wr_prescale)
                prescale_q <= wdata_q[15:0];
        end
    end

    assign tick = (pre_cnt == prescale_q);

    // Shadow duty swaps only at period start so a PWM cycle is never torn.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt  <= '0;
            pwm_cnt  <= '0;
            shadow_q <= '1;
        end else begin
            if (wr_prescale || tick)
                pre_cnt <= '0;
            else
                pre_cnt <= pre_cnt + 16'd1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
                if (pwm_cnt == 8'hFF)
                    shadow_q <= bright_q;
            end
        end
    end

    always_comb begin
        on = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            on[i] = ctrl_en & leds_i[i] & blink_gate[i]
                  & ((shadow_q[8*i +: 8] == 8'hFF)
                  || (pwm_cnt < shadow_q[8*i +: 8]));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            led_o <= '1;
        else
            led_o <= on ^ {NUM_LEDS{ctrl_inv}};
    end

endmodule
